vga_text_ctrl: RTL

- Text-mode write controller between the PS/2 keyboard ASCII stream and the VGA character memory.
- Tracks the cursor and turns keystrokes into character-RAM writes.
- Handles backspace, newline, line wrap and hardware scrolling via a rotating row base.
- The vmem read side adds scroll_base to the display row, so no line copying is ever needed.

---
 rtl/vga_text_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vga_text_ctrl.sv
// Text-mode write controller: keystrokes -> character-RAM writes, cursor, scroll.
// Optional VGA_TEXT_CLR_ON_RST_EN: sweep every cell with spaces after reset.
module vga_text_ctrl #(
   parameter int COLS  = 70,
   parameter int ROWS  = 30,
   parameter int COL_W = 7,
   parameter int ROW_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [7:0]       key_ascii,
   output logic             key_ready,
   output logic             wr_en,
   output logic [ROW_W-1:0] wr_row,
   output logic [COL_W-1:0] wr_col,
   output logic [7:0]       wr_char,
   output logic [ROW_W-1:0] scroll_base,
   output logic [ROW_W-1:0] cursor_row,
   output logic [COL_W-1:0] cursor_col,
   output logic             busy
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [7:0]       SPACE    = 8'h20;
   localparam logic [7:0]       BS       = 8'h08;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      CLEAR,
      CLRALL
   } state_e;

   state_e           state_q;
   logic [7:0]       key_q;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] base_q;
   logic             wr_en_q;
   logic [ROW_W-1:0] wr_row_q;
   logic [COL_W-1:0] wr_col_q;
   logic [7:0]       wr_char_q;

   function automatic logic is_print(input logic [7:0] k);
      return (k >= 8'h20) && (k <= 8'h7E);
   endfunction

   function automatic logic is_nl(input logic [7:0] k);
      return (k == 8'h0A) || (k == 8'h0D);
   endfunction

   // Logical -> physical row without a divider: both operands are < ROWS.
   function automatic logic [ROW_W-1:0] phys(
      input logic [ROW_W-1:0] base,
      input logic [ROW_W-1:0] r
   );
      logic [ROW_W:0] s;
      s = {1'b0, base} + {1'b0, r};
      if (s >= (ROW_W+1)'(ROWS))
         s = s - (ROW_W+1)'(ROWS);
      return s[ROW_W-1:0];
   endfunction

   logic [ROW_W-1:0] row_prev;
   logic [ROW_W-1:0] phys_cur;
   logic [ROW_W-1:0] phys_prev;
   logic             key_known;
   logic             nl_exec;

   assign row_prev  = row_q - ROW_W'(1);
   assign phys_cur  = phys(base_q, row_q);
   assign phys_prev = phys(base_q, row_prev);
   assign key_known = is_print(key_ascii) || is_nl(key_ascii)
                      || (key_ascii == BS);
   assign nl_exec   = is_nl(key_q)
                      || (is_print(key_q) && (col_q == COL_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q  <= '0;
         col_q  <= '0;
         base_q <= '0;
         key_q  <= '0;
`ifdef VGA_TEXT_CLR_ON_RST_EN
         state_q   <= CLRALL;
         wr_en_q   <= 1'b1;
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_char_q <= SPACE;
`else
         state_q   <= IDLE;
         wr_en_q   <= 1'b0;
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_char_q <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (key_valid && key_known) begin
                  key_q   <= key_ascii;
                  state_q <= EXEC;
                  if (is_print(key_ascii)) begin
                     wr_en_q   <= 1'b1;
                     wr_row_q  <= phys_cur;
                     wr_col_q  <= col_q;
                     wr_char_q <= key_ascii;
                  end else if (key_ascii == BS && col_q != '0) begin
                     wr_en_q   <= 1'b1;
                     wr_row_q  <= phys_cur;
                     wr_col_q  <= col_q - COL_W'(1);
                     wr_char_q <= SPACE;
                  end else if (key_ascii == BS && row_q != '0) begin
                     wr_en_q   <= 1'b1;
                     wr_row_q  <= phys_prev;
                     wr_col_q  <= COL_LAST;
                     wr_char_q <= SPACE;
                  end
               end
            end
            EXEC: begin
               wr_en_q <= 1'b0;
               state_q <= IDLE;
               if (nl_exec) begin
                  col_q <= '0;
                  if (row_q != ROW_LAST) begin
                     row_q <= row_q + ROW_W'(1);
                  end else begin
                     // Old top line becomes the new bottom line; blank it.
                     base_q    <= (base_q == ROW_LAST) ? '0
                                  : base_q + ROW_W'(1);
                     state_q   <= CLEAR;
                     wr_en_q   <= 1'b1;
                     wr_row_q  <= base_q;
                     wr_col_q  <= '0;
                     wr_char_q <= SPACE;
                  end
               end else if (key_q == BS) begin
                  if (col_q != '0) begin
                     col_q <= col_q - COL_W'(1);
                  end else if (row_q != '0) begin
                     row_q <= row_prev;
                     col_q <= COL_LAST;
                  end
               end else begin
                  col_q <= col_q + COL_W'(1);
               end
            end
            CLEAR: begin
               if (wr_col_q == COL_LAST) begin
                  wr_en_q <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  wr_col_q <= wr_col_q + COL_W'(1);
               end
            end
`ifdef VGA_TEXT_CLR_ON_RST_EN
            CLRALL: begin
               if (wr_col_q == COL_LAST) begin
                  if (wr_row_q == ROW_LAST) begin
                     wr_en_q <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     wr_col_q <= '0;
                     wr_row_q <= wr_row_q + ROW_W'(1);
                  end
               end else begin
                  wr_col_q <= wr_col_q + COL_W'(1);
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign key_ready   = (state_q == IDLE);
   assign busy        = ~key_ready;
   assign wr_en       = wr_en_q;
   assign wr_row      = wr_row_q;
   assign wr_col      = wr_col_q;
   assign wr_char     = wr_char_q;
   assign scroll_base = base_q;
   assign cursor_row  = row_q;
   assign cursor_col  = col_q;

endmodule
